// File: rtl/fp_pkg.sv
// Shared single-precision definitions: field layout, constants and the
// accumulator controller state encoding.
package fp_pkg;

  localparam logic [31:0] FP_ZERO     = 32'h0000_0000;
  localparam int          FP_SIGN_BIT = 31;
  localparam int          FP_EXP_MSB  = 30;
  localparam int          FP_EXP_LSB  = 23;
  localparam int          FP_MAN_MSB  = 22;
  localparam int          FP_MAN_LSB  = 0;
  localparam int          FP_EXP_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_RESULT    = 2'd3
  } fp_accum_state_t;

endpackage

// File: rtl/fp_accum_ctrl.sv
// Issue-side controller for the multi-cycle fpadd peer: accumulates a packet
// of single-precision values through the adder and returns the packet total.
module fp_accum_ctrl
  import fp_pkg::*;
#(
  parameter int TIMEOUT = 512,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_err,
  output logic             add_start,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_sum,
  input  logic             add_done
);

  localparam int               TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  fp_accum_state_t  state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic             last_q, last_d;
  logic [31:0]      add_a_q, add_a_d;
  logic [31:0]      add_b_q, add_b_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      acc_q   <= FP_ZERO;
      count_q <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
      add_a_q <= FP_ZERO;
      add_b_q <= FP_ZERO;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      err_q   <= err_d;
      last_q  <= last_d;
      add_a_q <= add_a_d;
      add_b_q <= add_b_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    err_d   = err_q;
    last_d  = last_q;
    add_a_d = add_a_q;
    add_b_d = add_b_q;
    tmo_d   = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          add_a_d = in_data;
          add_b_d = acc_q;
          last_d  = in_last;
          count_d = (&count_q) ? count_q : count_q + 1'b1;
          state_d = ST_ISSUE;
        end
      end
      // add_done may still be high from the previous operation; ignore it here.
      ST_ISSUE: begin
        tmo_d   = '0;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (add_done) begin
          acc_d   = add_sum;
          state_d = last_q ? ST_RESULT : ST_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_RESULT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_RESULT: begin
        if (out_ready) begin
          acc_d   = FP_ZERO;
          count_d = '0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign add_start = (state_q == ST_ISSUE);
  assign out_valid = (state_q == ST_RESULT);
  assign out_sum   = acc_q;
  assign out_count = count_q;
  assign out_err   = err_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;

endmodule

// File: tb/tb_fp_accum_ctrl.sv
// Directed bench for fp_accum_ctrl with a behavioural fpadd peer whose
// results come from a small table of hand-computed sums.
module tb_fp_accum_ctrl;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 16;
  localparam int WAIT_MAX = 600;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_data = 32'h0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_err;
  logic             add_start;
  logic [31:0]      add_a;
  logic [31:0]      add_b;
  logic [31:0]      add_sum;
  logic             add_done;

  int checks = 0;
  int errors = 0;

  fp_accum_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_count(out_count), .out_err(out_err),
    .add_start(add_start), .add_a(add_a), .add_b(add_b),
    .add_sum(add_sum), .add_done(add_done)
  );

  always #5 clk = ~clk;

  // Hand-computed IEEE-754 sums for the operand pairs used below.
  function automatic logic [31:0] fp_lookup(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F80_0000, 32'h0000_0000}: return 32'h3F80_0000; // 1.0 + 0
      {32'h4000_0000, 32'h0000_0000}: return 32'h4000_0000; // 2.0 + 0
      {32'h4000_0000, 32'h3F80_0000}: return 32'h4040_0000; // 2.0 + 1.0
      {32'h3F00_0000, 32'h4040_0000}: return 32'h4060_0000; // 0.5 + 3.0
      {32'h4000_0000, 32'h4000_0000}: return 32'h4080_0000; // 2.0 + 2.0
      default:                        return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Adder peer: done is a level cleared on the start edge.
  int          lat = 4;
  logic        hang = 1'b0;
  logic        busy = 1'b0;
  int          lat_cnt = 0;
  logic [31:0] op_a = 32'h0, op_b = 32'h0;
  logic        done_m = 1'b0;
  logic [31:0] sum_m = 32'h0;

  always @(posedge clk) begin
    if (add_start) begin
      done_m  <= 1'b0;
      busy    <= !hang;
      lat_cnt <= lat;
      op_a    <= add_a;
      op_b    <= add_b;
    end else if (busy) begin
      if (lat_cnt <= 1) begin
        done_m <= 1'b1;
        busy   <= 1'b0;
        sum_m  <= fp_lookup(op_a, op_b);
      end else begin
        lat_cnt <= lat_cnt - 1;
      end
    end
  end

  assign add_done = done_m;
  assign add_sum  = sum_m;

  // Start-pulse and operand-stability observation, sampled on the falling edge.
  int          starts = 0;
  int          dbl_starts = 0;
  int          opnd_changes = 0;
  logic        prev_start = 1'b0;
  logic        done_at_issue = 1'b0;
  logic [31:0] b_at_issue = 32'h0;
  logic [31:0] a_at_issue = 32'h0;

  always @(negedge clk) begin
    if (add_start) begin
      starts        <= starts + 1;
      done_at_issue <= add_done;
      b_at_issue    <= add_b;
      a_at_issue    <= add_a;
      if (prev_start) dbl_starts <= dbl_starts + 1;
    end else if (reset && !in_ready && !out_valid && (add_a != a_at_issue || add_b != b_at_issue)) begin
      opnd_changes <= opnd_changes + 1;
    end
    prev_start <= add_start;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < WAIT_MAX) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 32'(n), 32'(WAIT_MAX + 1));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < WAIT_MAX) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check({tag, "_no_result"}, 32'(out_valid), 32'h1);
  endtask

  task automatic take_result(input string tag, input logic [31:0] sum,
                             input logic [31:0] cnt, input logic err);
    check({tag, "_sum"}, out_sum, sum);
    check({tag, "_count"}, 32'(out_count), cnt);
    check({tag, "_err"}, 32'(out_err), 32'(err));
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    int s0;
    int n;
    logic [31:0] h_sum;
    logic [CNT_W-1:0] h_cnt;
    logic stable;

    #1;
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_add_start", 32'(add_start), 32'h0);
    check("rst_out_sum", out_sum, 32'h0);
    check("rst_add_a", add_a, 32'h0);
    check("rst_out_count", 32'(out_count), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // 1: single-element packet
    s0 = starts;
    lat = 5;
    send(32'h3F80_0000, 1'b1);
    wait_result("t1");
    check("t1_starts", 32'(starts - s0), 32'h1);
    check("t1_add_b", b_at_issue, 32'h0);
    take_result("t1", 32'h3F80_0000, 1, 1'b0);

    // 2: three elements with varied adder latency
    s0 = starts;
    lat = 3;
    send(32'h3F80_0000, 1'b0);
    lat = 7;
    send(32'h4000_0000, 1'b0);
    lat = 5;
    send(32'h3F00_0000, 1'b1);
    wait_result("t2");
    check("t2_starts", 32'(starts - s0), 32'h3);

    // 3: back-pressure in RESULT with a competing input
    h_sum = out_sum;
    h_cnt = out_count;
    stable = 1'b1;
    in_valid = 1'b1;
    in_data = 32'h4040_0000;
    in_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!out_valid || out_sum != h_sum || out_count != h_cnt || in_ready) stable = 1'b0;
    end
    check("t3_hold_stable", 32'(stable), 32'h1);
    check("t3_no_accept_starts", 32'(starts - s0), 32'h3);
    in_valid = 1'b0;
    take_result("t2", 32'h4060_0000, 3, 1'b0);

    // 4: stale done from the previous operation must be masked in ISSUE
    lat = 6;
    send(32'h4000_0000, 1'b0);
    @(negedge clk);
    check("t4_stale_done_at_issue", 32'(done_at_issue), 32'h1);
    send(32'h4000_0000, 1'b1);
    wait_result("t4");
    take_result("t4", 32'h4080_0000, 2, 1'b0);

    // 5: adder never completes the second operation
    lat = 4;
    send(32'h4000_0000, 1'b0);
    n = 0;
    while (!in_ready && n < WAIT_MAX) begin
      @(negedge clk);
      n++;
    end
    hang = 1'b1;
    send(32'h4000_0000, 1'b1);
    @(negedge clk);
    check("t5_issue", 32'(add_start), 32'h1);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < WAIT_MAX) begin
      n++;
      @(negedge clk);
    end
    // Cycles spent waiting in WAIT_DONE between ISSUE and RESULT.
    check("t5_wait_cycles", 32'(n), 32'(TIMEOUT));
    take_result("t5", 32'h4000_0000, 2, 1'b1);
    hang = 1'b0;
    lat = 4;
    send(32'h3F80_0000, 1'b1);
    wait_result("t5b");
    take_result("t5b", 32'h3F80_0000, 1, 1'b0);

    // 6: asynchronous reset while waiting for the adder
    lat = 12;
    send(32'h3F80_0000, 1'b0);
    repeat (4) @(negedge clk);
    check("t6_in_wait", 32'({in_ready, out_valid, add_start}), 32'h0);
    #1 reset = 1'b0;
    #1;
    check("t6_rst_in_ready", 32'(in_ready), 32'h1);
    check("t6_rst_add_start", 32'(add_start), 32'h0);
    check("t6_rst_add_a", add_a, 32'h0);
    check("t6_rst_out_count", 32'(out_count), 32'h0);
    check("t6_rst_out_valid", 32'(out_valid), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    lat = 5;
    send(32'h4000_0000, 1'b0);
    send(32'h4000_0000, 1'b1);
    wait_result("t6");
    take_result("t6", 32'h4080_0000, 2, 1'b0);

    check("start_pulse_width", 32'(dbl_starts), 32'h0);
    check("operand_stability", 32'(opnd_changes), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/fp_accum_ctrl.md
# fp_accum_ctrl

Issue-side controller for the multi-cycle single-precision adder (`fpadd`). It accepts a packet of IEEE-754 single values on a valid/ready stream and drives the adder's `start`/`done` handshake as initiator, feeding each value plus the running sum. It returns the packet total on an output valid/ready stream. It sits beside the adder in the parent; the adder is a peer instance, not a child.

## Interface
- `TIMEOUT`, default 512: maximum cycles to wait for `add_done` per operation.
- `CNT_W`, default 16: width of the element counter.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: input element valid.
- `in_ready`  out  1: controller can accept an element.
- `in_data`  in  32: single-precision element.
- `in_last`  in  1: element is the last of its packet.
- `out_valid`  out  1: packet result valid.
- `out_ready`  in  1: consumer accepts the result.
- `out_sum`  out  32: packet sum.
- `out_count`  out  CNT_W: elements in the packet, saturating.
- `out_err`  out  1: at least one adder operation timed out.
- `add_start`  out  1: adder start pulse.
- `add_a`  out  32: adder operand a (element).
- `add_b`  out  32: adder operand b (running sum).
- `add_sum`  in  32: adder result.
- `add_done`  in  1: adder done; level, held until the next start.

## Operation
States: IDLE, ISSUE, WAIT_DONE, RESULT.

- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&`in_ready`: `add_a`<=`in_data`, `add_b`<=acc, latch `in_last`, count<=count+1 (saturating at all-ones).
  - Go to ISSUE.
- **ISSUE**
  - `add_start`=1 for exactly this one cycle.
  - `add_done` is ignored here, because it may still be high from the previous operation. The adder clears `done` on the start edge.
  - Timeout counter <=0. Go to WAIT_DONE.
- **WAIT_DONE**
  - Sample `add_done` each cycle.
  - On `add_done`=1: acc<=`add_sum`. Go to RESULT if the latched last flag is set, otherwise go to IDLE.
  - If the counter reaches TIMEOUT-1 without `add_done`: set sticky err, leave acc unchanged, go to RESULT.
- **RESULT**
  - `out_valid`=1; `out_sum`=acc, `out_count`=count, `out_err`=err, all held stable.
  - On `out_ready`: acc<=32'h0000_0000, count<=0, err<=0, go to IDLE.

Rules:
- acc starts each packet at +0.0. The first element is still sent through the adder as x+0.0, which the adder handles by bypass.
- `add_a`/`add_b` stay constant from the accept cycle until `add_done` is captured or the operation times out.
- Elements are accepted only in IDLE, so `in_ready`=0 in all other states. A one-element packet is legal.
- After a timeout the adder's `done` is stale. The next packet's ISSUE cycle masks it.

## Timing
- Reset values (asynchronous, on `reset`=0):
  - State IDLE, so `in_ready`=1.
  - `out_valid`, `add_start`, `out_err` = 0.
  - `out_sum`, `add_a`, `add_b`, acc = 32'h0.
  - `out_count` = 0.
- All outputs are registered or decoded directly from state. There is no combinational path from input to output.
- Per element: accept cycle, 1 ISSUE cycle, adder latency L, then acc updates on the edge where `add_done`=1 is sampled.
  - L is variable: about 6 + |Δexp| + normalisation shifts, up to ~290 cycles.
  - The next element can be accepted in the cycle after `add_done` is captured.
- `out_valid` rises one cycle after the last element's `add_done` is sampled.
- Reset mid-operation returns to IDLE immediately and deasserts `add_start`. The adder is not reset by this block; its next `start` reloads it.
- `add_done` asserted together with the timeout expiry counts as done: the sum is captured and err is not set.

## Structure
- Shared package `fp_pkg` holds:
  - `FP_ZERO` = 32'h0000_0000.
  - Field positions: sign 31, exponent 30:23, mantissa 22:0.
  - Exponent width 8.
  - The state enum `fp_accum_state_t`.
- No sub-module. The timeout counter is inline, with width $clog2(TIMEOUT).

## Test plan
1. Single element 3F800000 with `in_last`=1 → exactly one `add_start` cycle with `add_b`=0; `out_sum`=3F800000, `out_count`=1, `out_err`=0.
2. Elements 3F800000, 40000000, 3F000000 (last) → three one-cycle start pulses; `out_sum`=40600000 (3.5), `out_count`=3.
3. Hold `out_ready`=0 for 10 cycles in RESULT → `out_valid`/`out_sum`/`out_count` stable and `in_ready`=0; an `in_valid` during this time is not accepted.
4. Adder model keeps `add_done`=1 from the previous operation until the start edge → nothing captured in ISSUE; 40000000+40000000 gives 40800000.
5. Adder model never asserts done with TIMEOUT=16 → RESULT entered 16 cycles after ISSUE with `out_err`=1 and `out_sum` equal to the previous acc; the following packet reports `out_err`=0.
6. Assert `reset` in WAIT_DONE → all outputs go to reset values without waiting for a clock; next packet 40000000, 40000000 (last) → `out_sum`=40800000, `out_count`=2.
